// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Scoreboard stall/forwarding controller for a 5-stage MIPS pipe.
//  Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic             rs_use_D,
    input  logic             rt_use_D,
    input  logic             tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [1:0]       tnew_D,
    input  logic [4:0]       waddr_D,
    input  logic             regwrite_D,
    output logic             stall,
    output logic [1:0]       fwd_rs_D,
    output logic [1:0]       fwd_rt_D,
    output logic [1:0]       fwd_rs_E,
    output logic [1:0]       fwd_rt_E,
    output logic             fwd_rt_M,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] c_SRC_NONE = 2'd0;
    localparam logic [1:0] c_SRC_E    = 2'd1;
    localparam logic [1:0] c_SRC_M    = 2'd2;
    localparam logic [1:0] c_SRC_W    = 2'd3;

    logic [4:0]       waddr_E_q, waddr_M_q, waddr_W_q;
    logic             we_E_q, we_M_q, we_W_q;
    logic [1:0]       tnew_E_q, tnew_M_q, tnew_W_q;
    logic [4:0]       rs_E_q, rt_E_q, rt_M_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [4:0]       waddr_E_d;
    logic             we_E_d;
    logic [1:0]       tnew_E_d;
    logic [4:0]       rs_E_d, rt_E_d;
    logic [CNT_W-1:0] stall_cnt_d;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic [1:0] tnew_of(input logic [1:0] src, input logic [1:0] te,
                                           input logic [1:0] tm, input logic [1:0] tw);
        case (src)
            c_SRC_E: return te;
            c_SRC_M: return tm;
            c_SRC_W: return tw;
            default: return 2'd0;
        endcase
    endfunction

    // Youngest producer wins; an older match behind it is stale.
    function automatic logic [1:0] e_fwd(input logic [4:0] s,
                                         input logic lm, input logic [4:0] wm, input logic [1:0] tm,
                                         input logic lw, input logic [4:0] ww, input logic [1:0] tw);
        if (s == 5'd0)              return c_SRC_NONE;
        if (lm && wm == s)          return (tm == 2'd0) ? c_SRC_M : c_SRC_NONE;
        if (lw && ww == s)          return (tw == 2'd0) ? c_SRC_W : c_SRC_NONE;
        return c_SRC_NONE;
    endfunction

    logic       w_live_E, w_live_M, w_live_W;
    logic [1:0] w_src_rs, w_src_rt, w_tnew_rs, w_tnew_rt;
    logic       w_stall_rs, w_stall_rt;

    assign w_live_E = we_E_q && (waddr_E_q != 5'd0);
    assign w_live_M = we_M_q && (waddr_M_q != 5'd0);
    assign w_live_W = we_W_q && (waddr_W_q != 5'd0);

    assign w_src_rs = (w_live_E && waddr_E_q == rs_D) ? c_SRC_E :
                      (w_live_M && waddr_M_q == rs_D) ? c_SRC_M :
                      (w_live_W && waddr_W_q == rs_D) ? c_SRC_W : c_SRC_NONE;
    assign w_src_rt = (w_live_E && waddr_E_q == rt_D) ? c_SRC_E :
                      (w_live_M && waddr_M_q == rt_D) ? c_SRC_M :
                      (w_live_W && waddr_W_q == rt_D) ? c_SRC_W : c_SRC_NONE;

    assign w_tnew_rs = tnew_of(w_src_rs, tnew_E_q, tnew_M_q, tnew_W_q);
    assign w_tnew_rt = tnew_of(w_src_rt, tnew_E_q, tnew_M_q, tnew_W_q);

    assign w_stall_rs = rs_use_D && (w_src_rs != c_SRC_NONE) && (w_tnew_rs > {1'b0, tuse_rs_D});
    assign w_stall_rt = rt_use_D && (w_src_rt != c_SRC_NONE) && (w_tnew_rt > tuse_rt_D);

    assign stall     = w_stall_rs | w_stall_rt;
    assign fwd_rs_D  = (w_tnew_rs == 2'd0) ? w_src_rs : c_SRC_NONE;
    assign fwd_rt_D  = (w_tnew_rt == 2'd0) ? w_src_rt : c_SRC_NONE;
    assign fwd_rs_E  = e_fwd(rs_E_q, w_live_M, waddr_M_q, tnew_M_q, w_live_W, waddr_W_q, tnew_W_q);
    assign fwd_rt_E  = e_fwd(rt_E_q, w_live_M, waddr_M_q, tnew_M_q, w_live_W, waddr_W_q, tnew_W_q);
    assign fwd_rt_M  = w_live_W && (waddr_W_q == rt_M_q) && (rt_M_q != 5'd0);
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        waddr_E_d   = waddr_D;
        we_E_d      = regwrite_D;
        tnew_E_d    = tnew_D;
        rs_E_d      = rs_D;
        rt_E_d      = rt_D;
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            waddr_E_d = 5'd0;
            we_E_d    = 1'b0;
            tnew_E_d  = 2'd0;
            rs_E_d    = 5'd0;
            rt_E_d    = 5'd0;
            if (~&stall_cnt_q) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr_E_q   <= 5'd0;
            we_E_q      <= 1'b0;
            tnew_E_q    <= 2'd0;
            rs_E_q      <= 5'd0;
            rt_E_q      <= 5'd0;
            waddr_M_q   <= 5'd0;
            we_M_q      <= 1'b0;
            tnew_M_q    <= 2'd0;
            rt_M_q      <= 5'd0;
            waddr_W_q   <= 5'd0;
            we_W_q      <= 1'b0;
            tnew_W_q    <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            waddr_E_q   <= waddr_E_d;
            we_E_q      <= we_E_d;
            tnew_E_q    <= tnew_E_d;
            rs_E_q      <= rs_E_d;
            rt_E_q      <= rt_E_d;
            waddr_M_q   <= waddr_E_q;
            we_M_q      <= we_E_q;
            tnew_M_q    <= sat_dec(tnew_E_q);
            rt_M_q      <= rt_E_q;
            waddr_W_q   <= waddr_M_q;
            we_W_q      <= we_M_q;
            tnew_W_q    <= sat_dec(tnew_M_q);
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Directed table, random-vs-model and async-reset checks for hazard_ctrl.
//  Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk, reset;
    logic [4:0]          rs_D, rt_D, waddr_D;
    logic                rs_use_D, rt_use_D, tuse_rs_D, regwrite_D;
    logic [1:0]          tuse_rt_D, tnew_D;
    logic                stall, fwd_rt_M;
    logic [1:0]          fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [TB_CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .tnew_D(tnew_D),
        .waddr_D(waddr_D), .regwrite_D(regwrite_D),
        .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       rsu, rtu, tus;
        logic [1:0] tut, tn;
        logic [4:0] wa;
        logic       we;
    } din_t;

    typedef struct {
        din_t d;
        int   st, frsd, frtd, frse, frte, frtm, cnt;
    } vec_t;

    // Reference model: an instruction list ordered youngest first (E, M, W),
    // each carrying its Tnew as it was at E entry.
    typedef struct {
        logic [4:0] wa, rs, rt;
        logic       we;
        int         tn;
    } instr_t;

    instr_t pipe [3];
    int     m_cnt;
    int     checks = 0;
    int     errors = 0;

    function automatic din_t mk(int rs, int rt, int rsu, int rtu, int tus, int tut,
                                int tn, int wa, int we);
        din_t d;
        d.rs = 5'(rs); d.rt = 5'(rt); d.rsu = 1'(rsu); d.rtu = 1'(rtu);
        d.tus = 1'(tus); d.tut = 2'(tut); d.tn = 2'(tn); d.wa = 5'(wa); d.we = 1'(we);
        return d;
    endfunction

    function automatic vec_t mv(din_t d, int st, int frsd, int frtd, int frse,
                                int frte, int frtm, int cnt);
        vec_t v;
        v.d = d; v.st = st; v.frsd = frsd; v.frtd = frtd;
        v.frse = frse; v.frte = frte; v.frtm = frtm; v.cnt = cnt;
        return v;
    endfunction

    function automatic int age_tnew(int k);
        int t;
        t = pipe[k].tn - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit live(int k);
        return pipe[k].we && pipe[k].wa != 5'd0;
    endfunction

    function automatic int find_prod(logic [4:0] s);
        for (int k = 0; k < 3; k++) if (live(k) && pipe[k].wa == s) return k;
        return -1;
    endfunction

    function automatic int m_dfwd(logic [4:0] s);
        int k;
        k = find_prod(s);
        return (k >= 0 && age_tnew(k) == 0) ? k + 1 : 0;
    endfunction

    function automatic int m_efwd(logic [4:0] s);
        if (s == 5'd0) return 0;
        for (int k = 1; k < 3; k++)
            if (live(k) && pipe[k].wa == s) return (age_tnew(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    function automatic int m_stall(din_t d);
        int kr, kt;
        kr = find_prod(d.rs);
        kt = find_prod(d.rt);
        if (d.rsu && kr >= 0 && age_tnew(kr) > int'(d.tus)) return 1;
        if (d.rtu && kt >= 0 && age_tnew(kt) > int'(d.tut)) return 1;
        return 0;
    endfunction

    function automatic vec_t model_expect(din_t d);
        int frtm;
        frtm = (live(2) && pipe[2].wa == pipe[1].rt && pipe[1].rt != 5'd0) ? 1 : 0;
        return mv(d, m_stall(d), m_dfwd(d.rs), m_dfwd(d.rt),
                  m_efwd(pipe[0].rs), m_efwd(pipe[0].rt), frtm, m_cnt);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{wa: 5'd0, rs: 5'd0, rt: 5'd0, we: 1'b0, tn: 0};
        m_cnt = 0;
    endtask

    task automatic model_clock(din_t d);
        int st;
        st = m_stall(d);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st != 0) begin
            pipe[0] = '{wa: 5'd0, rs: 5'd0, rt: 5'd0, we: 1'b0, tn: 0};
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            pipe[0] = '{wa: d.wa, rs: d.rs, rt: d.rt, we: d.we, tn: int'(d.tn)};
        end
    endtask

    task automatic drive(din_t d);
        rs_D = d.rs; rt_D = d.rt; rs_use_D = d.rsu; rt_use_D = d.rtu;
        tuse_rs_D = d.tus; tuse_rt_D = d.tut; tnew_D = d.tn;
        waddr_D = d.wa; regwrite_D = d.we;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, vec_t e);
        chk({tag, " stall"},     int'(stall),     e.st);
        chk({tag, " fwd_rs_D"},  int'(fwd_rs_D),  e.frsd);
        chk({tag, " fwd_rt_D"},  int'(fwd_rt_D),  e.frtd);
        chk({tag, " fwd_rs_E"},  int'(fwd_rs_E),  e.frse);
        chk({tag, " fwd_rt_E"},  int'(fwd_rt_E),  e.frte);
        chk({tag, " fwd_rt_M"},  int'(fwd_rt_M),  e.frtm);
        chk({tag, " stall_cnt"}, int'(stall_cnt), e.cnt);
    endtask

    // One pipeline cycle checked against the model; inputs already sit at posedge+1.
    task automatic model_cycle(string tag, din_t d);
        drive(d);
        @(negedge clk);
        check_all(tag, model_expect(d));
        @(posedge clk);
        model_clock(d);
        #1;
    endtask

    vec_t vecs [19];
    din_t IDLE, LW8A, ADDU989, ADDU8, BEQ80, ORI8, ADDU980, LW8, SW89, LUI0, BEQ00, d;
    int   last_st;

    initial begin
        IDLE    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        LW8A    = mk(9, 0, 1, 0, 1, 0, 2, 8, 1);
        ADDU989 = mk(8, 8, 1, 1, 1, 1, 1, 9, 1);
        ADDU8   = mk(1, 2, 1, 1, 1, 1, 1, 8, 1);
        BEQ80   = mk(8, 0, 1, 1, 0, 0, 0, 0, 0);
        ORI8    = mk(0, 0, 1, 0, 1, 0, 1, 8, 1);
        ADDU980 = mk(8, 0, 1, 1, 1, 1, 1, 9, 1);
        LW8     = mk(0, 0, 1, 0, 1, 0, 2, 8, 1);
        SW89    = mk(9, 8, 1, 1, 1, 2, 0, 0, 0);
        LUI0    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1);
        BEQ00   = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);

        //               din      st rsD rtD rsE rtE rtM cnt
        vecs[0]  = mv(IDLE,    0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mv(LW8A,    0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mv(ADDU989, 1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mv(ADDU989, 0, 0, 0, 0, 0, 0, 1);
        vecs[4]  = mv(IDLE,    0, 0, 0, 3, 3, 0, 1);
        vecs[5]  = mv(IDLE,    0, 0, 0, 0, 0, 0, 1);
        vecs[6]  = mv(ADDU8,   0, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mv(BEQ80,   1, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mv(BEQ80,   0, 2, 0, 0, 0, 0, 2);
        vecs[9]  = mv(IDLE,    0, 0, 0, 3, 0, 0, 2);
        vecs[10] = mv(ORI8,    0, 0, 0, 0, 0, 0, 2);
        vecs[11] = mv(ADDU980, 0, 0, 0, 0, 0, 0, 2);
        vecs[12] = mv(IDLE,    0, 0, 0, 2, 0, 0, 2);
        vecs[13] = mv(LW8,     0, 0, 0, 0, 0, 0, 2);
        vecs[14] = mv(SW89,    0, 3, 0, 0, 0, 0, 2);
        vecs[15] = mv(IDLE,    0, 0, 0, 0, 0, 0, 2);
        vecs[16] = mv(IDLE,    0, 0, 0, 0, 0, 1, 2);
        vecs[17] = mv(LUI0,    0, 0, 0, 0, 0, 0, 2);
        vecs[18] = mv(BEQ00,   0, 0, 0, 0, 0, 0, 2);

        reset = 1'b1;
        drive(IDLE);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].d);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            model_clock(vecs[i].d);
            #1;
        end

        last_st = 0;
        d = IDLE;
        for (int n = 0; n < 300; n++) begin
            if (last_st == 0) begin
                d = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2),
                       $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1));
            end
            last_st = m_stall(d);
            model_cycle($sformatf("rand%0d", n), d);
        end

        for (int n = 0; n < 3; n++) model_cycle($sformatf("flush%0d", n), IDLE);
        model_cycle("rst_lw", LW8);
        drive(BEQ80);
        @(negedge clk);
        check_all("rst_beq", model_expect(BEQ80));
        #2 reset = 1'b1;
        #1;
        check_all("rst_async", mv(BEQ80, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_all("rst_hold", mv(BEQ80, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        model_reset();
        model_cycle("rst_idle0", IDLE);
        model_cycle("rst_idle1", IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
